instr_fetch_buffer: RTL

Fetch-side consumer of the program counter: samples `pc_in` from the PC register, issues synchronous reads to instruction memory, and queues each returned instruction with its PC in a small FIFO. It presents them to decode under a valid/ready handshake. It sits between the PC register and the decoder. It drives `pc_advance` to gate PC stepping, and accepts `flush` from the branch-taken (`PCsrc`) path to discard wrong-path instructions.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_fifo.sv | 64 ++++++
 rtl/instr_fetch_buffer.sv | 94 +++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch buffer: FSM states,
// the buffered entry layout and the default datapath width.
package fetch_pkg;

    localparam int FETCH_DW = 32;

    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [FETCH_DW-1:0] pc;
        logic [FETCH_DW-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Circular buffer of fetch entries with push, pop and clear.
// Ports: clk_i, rst_ni, clear_i, push_i, pop_i, wdata_i -> rdata_o (head), count_o.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clear_i,
    input  logic         push_i,
    input  logic         pop_i,
    input  fetch_entry_t wdata_i,
    output fetch_entry_t rdata_o,
    output logic [CW-1:0] count_o
);

    fetch_entry_t  mem_q [DEPTH];
    logic [PW-1:0] wr_q, wr_d;
    logic [PW-1:0] rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // DEPTH is a power of two, so pointer overflow is the wrap.
    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (clear_i) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (push_i) wr_d = wr_q + 1'b1;
            if (pop_i)  rd_d = rd_q + 1'b1;
            case ({push_i, pop_i})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i && !clear_i) mem_q[wr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_q];
    assign count_o = cnt_q;

endmodule

// File: rtl/instr_fetch_buffer.sv
// Fetch stage: issues imem reads at pc_in, queues returned instructions with
// their PC and hands them to decode under valid/ready; flush drops wrong-path work.
// Ports: clk, rst (async, active-low), pc_in, flush, pc_advance, imem_rd_en,
// imem_addr, imem_rdata, dec_valid, dec_ready, dec_instr, dec_pc.
module instr_fetch_buffer
    import fetch_pkg::*;
#(
    parameter int DATA_WIDTH = FETCH_DW,
    parameter int DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] pc_in,
    input  logic                  flush,
    output logic                  pc_advance,
    output logic                  imem_rd_en,
    output logic [DATA_WIDTH-1:0] imem_addr,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    output logic                  dec_valid,
    input  logic                  dec_ready,
    output logic [DATA_WIDTH-1:0] dec_instr,
    output logic [DATA_WIDTH-1:0] dec_pc
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_t          state_q, state_d;
    logic                  inflight_q, inflight_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_d;

    logic [CW-1:0] count;
    logic [CW:0]   occ;
    logic          push;
    logic          pop;
    fetch_entry_t  wentry;
    fetch_entry_t  hentry;

    assign dec_valid = (count != '0) & ~flush;
    assign pop       = dec_valid & dec_ready;

    // Entries the buffer will hold after this edge, counting the
    // read still on its way back from memory.
    assign occ = {1'b0, count} + (CW+1)'(inflight_q) - (CW+1)'(pop);

    assign imem_rd_en = (state_q != S_RESET) & ~flush
                      & (occ < (CW+1)'(DEPTH));
    assign pc_advance = imem_rd_en;
    assign imem_addr  = pc_in;

    // Data returning in the flush-recovery cycle belongs to the old path.
    assign push = inflight_q & ~flush & (state_q != S_FLUSH);

    always_comb begin
        state_d    = state_q;
        inflight_d = imem_rd_en;
        pc_d       = imem_rd_en ? pc_in : pc_q;
        unique case (state_q)
            S_RESET: state_d = S_RUN;
            S_RUN:   state_d = flush ? S_FLUSH : S_RUN;
            S_FLUSH: state_d = flush ? S_FLUSH : S_RUN;
            default: state_d = S_RESET;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_RESET;
            inflight_q <= 1'b0;
            pc_q       <= '0;
        end else begin
            state_q    <= state_d;
            inflight_q <= inflight_d;
            pc_q       <= pc_d;
        end
    end

    assign wentry.pc    = FETCH_DW'(pc_q);
    assign wentry.instr = FETCH_DW'(imem_rdata);

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i   (clk),
        .rst_ni  (rst),
        .clear_i (flush),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (wentry),
        .rdata_o (hentry),
        .count_o (count)
    );

    assign dec_pc    = DATA_WIDTH'(hentry.pc);
    assign dec_instr = DATA_WIDTH'(hentry.instr);

endmodule
